// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_unit and by anything that inspects its state.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      HAVE  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Redirect targets are word addresses; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, talks req/ack to a variable-latency
// instruction memory, and presents either a fetched word or a NOP bubble to IF/ID.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_PC4,
   output logic [31:0] IF_Inst,
   output logic        IF_Valid
);

   fetch_state_t state, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  target;

   assign target = word_align(redirect_pc);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
      state_d = state;
      pc_d    = pc_q;
      inst_d  = inst_q;
      tgt_d   = tgt_q;

      unique case (state)
         REQ: begin
            if (redirect && imem_ack) begin
               pc_d = target;
            end else if (redirect) begin
               tgt_d   = target;
               state_d = FLUSH;
            end else if (imem_ack) begin
               inst_d  = imem_rdata;
               state_d = HAVE;
            end
         end
         HAVE: begin
            if (redirect) begin
               pc_d    = target;
               state_d = REQ;
            end else if (!stall) begin
               pc_d    = pc_q + PC_STEP;
               state_d = REQ;
            end
         end
         FLUSH: begin
            // The stale request stays up until acked; only then is the newest target taken.
            if (imem_ack) begin
               pc_d    = redirect ? target : tgt_q;
               state_d = REQ;
            end else if (redirect) begin
               tgt_d = target;
            end
         end
         default: state_d = REQ;
      endcase
   end

   // NOTE: Clrn is sampled on the clock edge only; state uses non-blocking assignments throughout.
   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         state  <= REQ;
         pc_q   <= RESET_PC;
         inst_q <= NOP_INST;
         tgt_q  <= '0;
      end else begin
         state  <= state_d;
         pc_q   <= pc_d;
         inst_q <= inst_d;
         tgt_q  <= tgt_d;
      end
   end

   assign imem_req  = Clrn && (state != HAVE);
   assign imem_addr = pc_q;

   assign IF_PC    = pc_q;
   assign IF_PC4   = pc_q + PC_STEP;
   assign IF_Valid = (state == HAVE);
   assign IF_Inst  = (state == HAVE) ? inst_q : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a behavioural fetch model; a second instance covers PC wrap.
module tb_fetch_unit;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] SALT  = 32'hA5A5_A5A5;

   logic        Clk = 1'b0;
   logic        Clrn = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] IF_PC, IF_PC4, IF_Inst;
   logic        IF_Valid;

   logic        w_clrn = 1'b0;
   logic        w_stall = 1'b0;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = '0;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = '0;
   logic [31:0] w_pc, w_pc4, w_inst;
   logic        w_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: current PC, whether an instruction is being presented,
   // whether the outstanding request is to be thrown away, and where to go after.
   logic [31:0] m_pc   = '0;
   bit          m_have = 1'b0;
   bit          m_drop = 1'b0;
   logic [31:0] m_inst = NOP;
   logic [31:0] m_tgt  = '0;

   always #5 Clk = ~Clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .Clk(Clk), .Clrn(Clrn), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_PC(IF_PC),
      .IF_PC4(IF_PC4), .IF_Inst(IF_Inst), .IF_Valid(IF_Valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
      .Clk(Clk), .Clrn(w_clrn), .stall(w_stall), .redirect(w_redirect),
      .redirect_pc(w_redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata), .IF_PC(w_pc),
      .IF_PC4(w_pc4), .IF_Inst(w_inst), .IF_Valid(w_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   task automatic model_edge(input bit rn, input bit s, input bit r,
                             input logic [31:0] rpc, input bit a, input logic [31:0] rd);
      if (!rn) begin
         m_pc = dut.RESET_PC; m_have = 0; m_drop = 0; m_inst = NOP; m_tgt = '0;
      end else if (m_have) begin
         if (r) begin
            m_pc = align(rpc); m_have = 0;
         end else if (!s) begin
            m_pc = m_pc + 32'd4; m_have = 0;
         end
      end else if (m_drop) begin
         if (a) begin
            m_pc = r ? align(rpc) : m_tgt; m_drop = 0;
         end else if (r) begin
            m_tgt = align(rpc);
         end
      end else begin
         if (r && a) m_pc = align(rpc);
         else if (r) begin
            m_tgt = align(rpc); m_drop = 1;
         end else if (a) begin
            m_inst = rd; m_have = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("imem_req",  {31'b0, imem_req}, {31'b0, Clrn && !m_have});
      chk("imem_addr", imem_addr, m_pc);
      chk("IF_PC",     IF_PC, m_pc);
      chk("IF_PC4",    IF_PC4, m_pc + 32'd4);
      chk("IF_Inst",   IF_Inst, m_have ? m_inst : NOP);
      chk("IF_Valid",  {31'b0, IF_Valid}, {31'b0, m_have});
   endtask

   // One clock of main-DUT stimulus; inputs change just after a falling edge.
   task automatic step(input bit rn, input bit s, input bit r,
                       input logic [31:0] rpc, input bit a);
      bit req_exp;
      req_exp     = rn && !m_have;
      Clrn        = rn;
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
      imem_ack    = a && req_exp;
      imem_rdata  = m_pc ^ SALT;
      #1;
      chk("req_pre", {31'b0, imem_req}, {31'b0, req_exp});
      if (req_exp) chk("addr_pre", imem_addr, m_pc);
      @(posedge Clk);
      model_edge(rn, s, r, rpc, a && req_exp, m_pc ^ SALT);
      @(negedge Clk);
      check_outputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge Clk);

      // Reset, then a zero-wait memory.
      step(0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      chk("reset_req_low", {31'b0, imem_req}, 32'd0);
      step(1, 0, 0, '0, 1);
      chk("first_inst", IF_Inst, 32'hA5A5_A5A5);
      chk("first_pc4", IF_PC4, 32'd4);
      step(1, 0, 0, '0, 0);
      chk("second_req_addr", imem_addr, 32'd4);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 1);

      // Stall in HAVE at PC 8.
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, '0, 0);
         chk("stall_pc", IF_PC, 32'd8);
         chk("stall_valid", {31'b0, IF_Valid}, 32'd1);
      end
      step(1, 0, 0, '0, 0);
      chk("after_stall_addr", imem_addr, 32'd12);

      // Three wait states, then the ack.
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, '0, 0);
         chk("wait_inst_nop", IF_Inst, NOP);
         chk("wait_addr", imem_addr, 32'd12);
      end
      step(1, 0, 0, '0, 1);
      chk("wait_inst", IF_Inst, 32'd12 ^ SALT);

      // Redirect while a request to 0x20 is outstanding.
      step(1, 0, 1, 32'h20, 0);
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, 32'h100, 0);
      step(1, 0, 0, '0, 0);
      chk("flush_addr", imem_addr, 32'h20);
      step(1, 0, 0, '0, 1);
      chk("flush_drop_valid", {31'b0, IF_Valid}, 32'd0);
      chk("flush_next_addr", imem_addr, 32'h100);

      // Two redirects during FLUSH: the latest wins.
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, 32'h300, 0);
      step(1, 0, 1, 32'h200, 0);
      step(1, 0, 0, '0, 1);
      chk("latest_redirect", imem_addr, 32'h200);

      // Redirect beats stall; unaligned target.
      step(1, 0, 0, '0, 1);
      step(1, 1, 1, 32'h0000_0103, 0);
      chk("redirect_over_stall", imem_addr, 32'h100);
      chk("redirect_req", {31'b0, imem_req}, 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         bit rn, s, r, a;
         logic [31:0] rpc;
         rn  = ($urandom_range(0, 99) != 0);
         s   = ($urandom_range(0, 1) == 1);
         r   = ($urandom_range(0, 9) == 0);
         a   = ($urandom_range(0, 9) < 4);
         rpc = $urandom;
         step(rn, s, r, rpc, a);
      end

      // PC wrap on the second instance.
      w_clrn = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      chk("wrap_reset_req", {31'b0, w_req}, 32'd0);
      chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", w_pc4, 32'h0000_0000);
      w_clrn  = 1'b1;
      w_ack   = 1'b1;
      w_rdata = 32'hDEAD_BEEF;
      #1;
      chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      @(posedge Clk);
      @(negedge Clk);
      w_ack = 1'b0;
      chk("wrap_have_inst", w_inst, 32'hDEAD_BEEF);
      chk("wrap_have_pc4", w_pc4, 32'h0000_0000);
      @(posedge Clk);
      @(negedge Clk);
      chk("wrap_next_req", {31'b0, w_req}, 32'd1);
      chk("wrap_next_addr", w_addr, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage controller that drives the IF side of the IF/ID pipeline register. Owns the program counter, runs a request/acknowledge handshake with a variable-latency instruction memory, and honours the same `stall` that freezes IF/ID. Also handles branch/jump redirects, including redirects that arrive while a memory request is outstanding. When no valid instruction is available, it presents a NOP so IF/ID captures a bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, default 32'h0000_0000: instruction presented when no valid fetch is available.

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Clrn`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold request from hazard logic; the same signal drives IF/ID.
- `redirect`  in  1  taken branch/jump; one-cycle pulse.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  read data valid this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack`=1.
- `IF_PC`  out  32  PC of the presented instruction.
- `IF_PC4`  out  32  `IF_PC` + 4.
- `IF_Inst`  out  32  presented instruction, or `NOP_INST`.
- `IF_Valid`  out  1  `IF_Inst` is a real fetched instruction.

## Operation
- **Registers:**
  - `pc_q`: 32-bit program counter.
  - `inst_q`: 32-bit captured instruction.
  - `tgt_q`: 32-bit pending redirect target.
  - `state`: one of REQ, HAVE, FLUSH.
- **Reset** (`Clrn`=0 at edge):
  - `pc_q`=`RESET_PC`, `inst_q`=`NOP_INST`, `tgt_q`=0, `state`=REQ.
  - While `Clrn`=0, `imem_req` is forced to 0 combinationally.
  - Reset mid-request abandons that request; an ack arriving later in REQ is accepted as data for `RESET_PC`, which is the memory's responsibility.
- **Output derivation:**
  - `IF_PC`=`pc_q`.
  - `IF_PC4`=`pc_q`+4, modulo 2^32, so 32'hFFFF_FFFC yields 0.
  - `IF_Inst`=`inst_q` and `IF_Valid`=1 only in HAVE; otherwise `IF_Inst`=`NOP_INST` and `IF_Valid`=0.
  - `imem_addr`=`pc_q` in every state.
- **State REQ** (`imem_req`=1, `imem_addr`=`pc_q`):
  - redirect & ack: discard data; `pc_q`=target; stay REQ.
  - redirect & !ack: `tgt_q`=target; go to FLUSH.
  - ack & !redirect: `inst_q`=`imem_rdata`; go to HAVE. This happens regardless of `stall`.
  - otherwise: wait.
- **State HAVE** (`imem_req`=0):
  - redirect: `pc_q`=target; go to REQ. Redirect overrides `stall`.
  - !stall: `pc_q`=`pc_q`+4 (wraps); go to REQ.
  - stall: hold all registers.
- **State FLUSH** (`imem_req`=1, `imem_addr`=old `pc_q`). The request is held so the memory contract is kept:
  - ack: discard data; `pc_q`=`tgt_q`, or `redirect_pc` if `redirect` is high the same cycle; go to REQ.
  - redirect & !ack: `tgt_q`=`redirect_pc`; the latest redirect wins.
- **Memory contract:** once `imem_req` rises, `imem_addr` is stable until the ack cycle inclusive. `imem_req` may stay high on the cycle after an ack in REQ→REQ, and that counts as a new request.
- **Priority:** Clrn > redirect > ack > stall.

## Timing
- Zero-wait memory (ack in the first request cycle) gives one instruction per 2 cycles: REQ, then HAVE.
- N wait cycles give N+2 cycles per instruction.
- Redirect to first request at the target:
  - from HAVE: 1 cycle;
  - from REQ with ack: 1 cycle;
  - from REQ without ack: ack latency + 1.
- IF/ID samples on the falling edge. All IF_* outputs change only on rising edges, so they are stable at capture.
- Under `stall` in HAVE, outputs are frozen indefinitely.
- `stall` in REQ or FLUSH has no effect. The bubble NOP is held by IF/ID anyway.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {REQ, HAVE, FLUSH};
  - `NOP_INST` default constant;
  - `PC_STEP`=4.
- Single module; no sub-module is warranted. The PC incrementer and next-state logic are inline.

## Test plan
- **Reset, zero-wait memory:** hold `Clrn`=0 for 2 cycles, then ack every request with rdata=addr^32'hA5A5_A5A5.
  - `imem_req`=0 during reset.
  - First request is to address 0.
  - HAVE presents `IF_PC`=0, `IF_PC4`=4, `IF_Inst`=32'hA5A5_A5A5.
  - Next request is to address 4, two cycles later.
- **Stall in HAVE:** assert `stall` for 5 cycles at `pc_q`=8.
  - `IF_PC`=8 and `IF_Valid`=1 are frozen.
  - `imem_req`=0 throughout.
  - Address 12 is requested on the cycle after `stall` drops.
- **Wait states:** ack 3 cycles after the request.
  - `IF_Valid`=0 and `IF_Inst`=`NOP_INST` for 3 cycles.
  - `imem_addr` is stable until the ack.
  - The instruction appears in the following cycle.
- **Redirect during outstanding request:** redirect to 32'h100 one cycle into a 3-cycle request at address 0x20.
  - FLUSH holds address 0x20 until the ack.
  - The data is dropped and never becomes valid.
  - Next request is 32'h100.
  - A second redirect to 32'h200 in FLUSH makes the next request 32'h200 instead.
- **Redirect vs stall, unaligned target:** in HAVE with `stall`=1, redirect to 32'h0000_0103.
  - Next cycle: REQ at 32'h0000_0100.
- **PC wrap:** `RESET_PC`=32'hFFFF_FFFC.
  - `IF_PC4`=0.
  - After the non-stalled HAVE, the next request address is 0.
